// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, operand forwarding and mult/div busy-wait.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_md,
    input  logic       branch_taken,
    input  logic       exe_write,
    input  logic [4:0] exe_waddr,
    input  logic       exe_is_load,
    input  logic       mem_write,
    input  logic [4:0] mem_waddr,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idexe_flush,
    output logic       md_start,
    output logic       md_busy,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    // state      | meaning
    // ST_RUN     | normal issue; resolves load-use stalls, branches, md launch
    // ST_MD_WAIT | front end frozen while the MD unit counts down
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt, lu;

    assign exe_hit_rs = exe_write && (exe_waddr != 5'd0) && (exe_waddr == id_rs);
    assign exe_hit_rt = exe_write && (exe_waddr != 5'd0) && (exe_waddr == id_rt);
    assign mem_hit_rs = mem_write && (mem_waddr != 5'd0) && (mem_waddr == id_rs);
    assign mem_hit_rt = mem_write && (mem_waddr != 5'd0) && (mem_waddr == id_rt);
    assign lu = exe_is_load && ((id_use_rs && exe_hit_rs) || (id_use_rt && exe_hit_rt));

    // A load in EXE has no data yet, so it cannot be an EXE forward source.
    always_comb begin
        fwd_rs = 2'd0;
        fwd_rt = 2'd0;
        if (exe_hit_rs && !exe_is_load) fwd_rs = 2'd1;
        else if (mem_hit_rs)            fwd_rs = 2'd2;
        if (exe_hit_rt && !exe_is_load) fwd_rt = 2'd1;
        else if (mem_hit_rt)            fwd_rt = 2'd2;
        if (!rst) begin
            fwd_rs = 2'd0;
            fwd_rt = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (lu) begin
                    idexe_flush = 1'b1;
                end else if (id_is_md) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    md_start = 1'b1;
                    state_d  = ST_MD_WAIT;
                    cnt_d    = CNT_W'(MD_LATENCY - 1);
                end else if (branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                md_busy     = 1'b1;
                idexe_flush = 1'b1;
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                idexe_flush = 1'b1;
                state_d     = ST_RUN;
                cnt_d       = '0;
            end
        endcase
        // Reset forces a fully bubbled, frozen front end regardless of state.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            md_start    = 1'b0;
            md_busy     = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
            if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the enable/flush controls of the IF/ID and ID/EXE pipeline registers and the PC.
- Selects operand forwarding sources from the EXE/MEM and MEM/WB stages.
- Sequences multi-cycle mult/div operations with a busy-wait state machine.

Parameters:
- MD_LATENCY, 32, cycles a mult/div occupies the MD unit after md_start (legal range 2..255).
- CNT_W, 8, width of the MD cycle counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_is_md  in  1  ID instruction is mult/multu/div/divu.
- branch_taken  in  1  branch/jump resolved taken in ID.
- exe_write  in  1  EXE instruction writes the register file.
- exe_waddr  in  5  EXE destination register.
- exe_is_load  in  1  EXE instruction is a load (write data comes from DM).
- mem_write  in  1  MEM instruction writes the register file.
- mem_waddr  in  5  MEM destination register.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register clear (bubble).
- idexe_flush  out  1  ID/EXE register clear (bubble).
- md_start  out  1  one-cycle start pulse to the MD unit.
- md_busy  out  1  MD operation in flight.
- fwd_rs  out  2  rs source: 0 = regfile, 1 = EXE ALU result, 2 = MEM result.
- fwd_rt  out  2  rt source, same encoding as fwd_rs.

Behaviour:
- Reset: clk and rst as listed; rst asynchronous, active-low. While rst=0:
  - state=RUN, cnt=0.
  - pc_en=0, ifid_en=0, ifid_flush=1, idexe_flush=1, md_start=0, md_busy=0, fwd_rs=0, fwd_rt=0.
- Matching rules:
  - A register match requires the write flag set and a nonzero address; $0 never matches.
  - Load-use hazard (lu): exe_is_load & exe_write & exe_waddr!=0 & ((id_use_rs & id_rs==exe_waddr) | (id_use_rt & id_rt==exe_waddr)).
- Forwarding (combinational, every state):
  - fwd_rs=1 if EXE matches rs and exe_is_load=0.
  - Otherwise fwd_rs=2 if MEM matches rs.
  - Otherwise fwd_rs=0.
  - EXE beats MEM when both match. fwd_rt is identical using rt.
- State RUN, evaluated in priority order:
  1. lu=1: pc_en=0, ifid_en=0, idexe_flush=1, ifid_flush=0. Stays in RUN. The hazard clears the next cycle because the load has moved to MEM and is forwarded via fwd=2. Lasts exactly 1 cycle.
  2. id_is_md=1: md_start=1 for this cycle; the MD instruction advances normally. Next state MD_WAIT, cnt<=MD_LATENCY-1.
  3. branch_taken=1: ifid_flush=1; pc_en=1, ifid_en=1.
  4. Otherwise: pc_en=1, ifid_en=1, both flushes 0.
- A branch_taken arriving during an lu stall is ignored. ID is held, so the branch is re-evaluated next cycle.
- State MD_WAIT:
  - md_busy=1, pc_en=0, ifid_en=0, idexe_flush=1, md_start=0.
  - cnt decrements each cycle; when cnt==0, next state is RUN.
  - Total front-end freeze = MD_LATENCY cycles after the md_start cycle.
  - branch_taken and id_is_md are ignored in this state.
- Reset asserted mid-MD_WAIT aborts the sequence: state=RUN, cnt=0, no md_start is reissued after reset.
- No state other than RUN/MD_WAIT exists. Any illegal encoding returns to RUN on the next clock.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Enabled:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0.
  - stall_cycles increments on every cycle with pc_en=0 and rst=1.
  - flush_count increments on every cycle with ifid_flush=1 and rst=1.
  - Both saturate at 32'hFFFFFFFF.
- Disabled: the ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → pc_en=1, ifid_en=1, flushes 0, md_busy=0 on the first cycle after release.
- Load-use: exe_is_load=1, exe_write=1, exe_waddr=5, id_rs=5, id_use_rs=1 → one cycle of pc_en=0, idexe_flush=1. Next cycle, with mem_waddr=5, mem_write=1 → fwd_rs=2, pc_en=1.
- Forward priority: exe_waddr=mem_waddr=7, both writes=1, exe_is_load=0, id_rt=7 → fwd_rt=1. With exe_waddr=0 and mem_waddr=0 → fwd_rt=0.
- MD sequence, MD_LATENCY=4: id_is_md=1 → md_start high 1 cycle, then md_busy=1 and pc_en=0 for exactly 4 cycles, then RUN. branch_taken=1 during the wait produces no ifid_flush.
- Branch vs load-use: lu=1 and branch_taken=1 in the same cycle → idexe_flush=1, ifid_flush=0. Next cycle (lu cleared), branch_taken=1 → ifid_flush=1.
- Reset mid-op: rst=0 two cycles into MD_WAIT → md_busy=0 immediately (async). After release: state RUN, pc_en=1, no md_start pulse.
